// File: rtl/lock_key_conditioner.sv
// Front-panel key conditioner: per-key 2-flop synchroniser, tick-sampled debounce,
// and a per-key repeat FSM that turns debounced presses into one-clock strobes.
module lock_key_conditioner #(
    parameter int         TICK_DIV   = 50000,
    parameter int         DB_TICKS   = 10,
    parameter int         RPT_DELAY  = 500,
    parameter int         RPT_PERIOD = 150,
    parameter logic [5:0] RPT_MASK   = 6'b001111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] btn_in,
    output logic [5:0] key_level,
    output logic [5:0] key_pulse,
    output logic       any_pulse,
    output logic       tick
);

    localparam int NK   = 6;
    localparam int PW   = $clog2(TICK_DIV);
    localparam int DW   = $clog2(DB_TICKS + 1);
    localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_TICKS - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DELAY);
    localparam logic [RW-1:0] PER_LAST = RW'(RPT_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2,
        S_HELD   = 2'd3
    } rpt_state_e;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    logic [NK-1:0] sync0_q, sync1_q;
    logic [NK-1:0] level_q, level_d;
    logic [DW-1:0] db_cnt_q [NK];
    logic [DW-1:0] db_cnt_d [NK];
    rpt_state_e    state_q [NK];
    rpt_state_e    state_d [NK];
    logic [RW-1:0] rpt_cnt_q [NK];
    logic [RW-1:0] rpt_cnt_d [NK];
    logic [NK-1:0] pulse_q, pulse_d;
    logic          any_q;

    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        tick_d = (pre_q == PRE_LAST);
    end

    // Debounce counts consecutive disagreeing ticks; the flip happens on the tick
    // that would bring the count to DB_TICKS, so the counter never holds that value.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NK; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (tick_q) begin
                if (sync1_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        level_d[i]  = ~level_q[i];
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end
        end
    end

    // Terminal counts are acted on the cycle after the tick that reaches them,
    // so a same-cycle debounced release always wins and suppresses the pulse.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NK; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            if (!level_q[i]) begin
                state_d[i]   = S_IDLE;
                rpt_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        pulse_d[i]   = 1'b1;
                        rpt_cnt_d[i] = '0;
                        state_d[i]   = RPT_MASK[i] ? S_DELAY : S_HELD;
                    end
                    S_DELAY: begin
                        if (rpt_cnt_q[i] == DLY_LAST) begin
                            pulse_d[i]   = 1'b1;
                            rpt_cnt_d[i] = '0;
                            state_d[i]   = S_REPEAT;
                        end else if (tick_q) begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                        end
                    end
                    S_REPEAT: begin
                        if (rpt_cnt_q[i] == PER_LAST) begin
                            pulse_d[i]   = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else if (tick_q) begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                        end
                    end
                    S_HELD: begin
                        state_d[i] = S_HELD;
                    end
                    default: begin
                        state_d[i]   = S_IDLE;
                        rpt_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            sync0_q <= '0;
            sync1_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < NK; i++) begin
                db_cnt_q[i]  <= '0;
                state_q[i]   <= S_IDLE;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            sync0_q <= btn_in;
            sync1_q <= sync0_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            any_q   <= |pulse_d;
            for (int i = 0; i < NK; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    assign key_level = level_q;
    assign key_pulse = pulse_q;
    assign any_pulse = any_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_lock_key_conditioner.sv
// Directed bench for lock_key_conditioner with small timing parameters; expected
// latencies and repeat tick offsets are hand-computed for TICK_DIV=4, DB=3, delay 5, period 2.
module tb_lock_key_conditioner;

    localparam int TICK_DIV   = 4;
    localparam int DB_TICKS   = 3;
    localparam int RPT_DELAY  = 5;
    localparam int RPT_PERIOD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] btn_in;
    logic [5:0] key_level;
    logic [5:0] key_pulse;
    logic       any_pulse;
    logic       tick;

    lock_key_conditioner #(
        .TICK_DIV  (TICK_DIV),
        .DB_TICKS  (DB_TICKS),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD),
        .RPT_MASK  (6'b001111)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .key_level(key_level),
        .key_pulse(key_pulse),
        .any_pulse(any_pulse),
        .tick     (tick)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          tick_n     = 0;
    int          any_cnt    = 0;
    int          wide_err   = 0;
    int          any_err    = 0;
    int          watch      = 0;
    int          pcnt [6]   = '{0, 0, 0, 0, 0, 0};
    logic [5:0]  prev_pulse = '0;
    logic [5:0]  last_vec   = '0;
    logic [31:0] ev_q [$];
    logic [31:0] exp_q [$];

    // monitor samples on the falling edge
    always @(negedge clk) begin
        if (tick) tick_n++;
        for (int i = 0; i < 6; i++)
            if (key_pulse[i]) pcnt[i]++;
        if (any_pulse) any_cnt++;
        if (key_pulse != 6'd0) last_vec = key_pulse;
        if ((key_pulse & prev_pulse) != 6'd0) wide_err++;
        if (any_pulse !== (|key_pulse)) any_err++;
        if (key_pulse[watch]) ev_q.push_back(32'(tick_n));
        prev_pulse = key_pulse;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver helpers; all sample at posedge+1
    task automatic skip_ticks(input int k);
        int seen = 0;
        for (int g = 0; g < k * 8 + 8 && seen < k; g++) begin
            @(posedge clk); #1;
            if (tick) seen++;
        end
        if (seen < k) check("skip_ticks_bound", 32'(seen), 32'(k));
    endtask

    task automatic ticks_until(input int b, input logic val, output int n);
        n = 0;
        for (int g = 0; g < 400; g++) begin
            @(posedge clk); #1;
            if (key_level[b] === val) return;
            if (tick) n++;
        end
        n = -1;
    endtask

    task automatic check_events(input string tag);
        int nexp = exp_q.size();
        check({tag, "_count"}, 32'(ev_q.size()), 32'(nexp));
        for (int k = 0; k < nexp; k++) begin
            logic [31:0] got;
            got = (k < ev_q.size()) ? ev_q[k] - ev_q[0] : 32'hFFFF_FFFF;
            check($sformatf("%s_rel%0d", tag, k), got, exp_q[k]);
        end
        exp_q.delete();
    endtask

    int n;
    int p0;
    int p_any;

    initial begin
        reset  = 1'b1;
        btn_in = 6'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 32'(key_level), 0);
        check("rst_pulse", 32'(key_pulse), 0);
        check("rst_any", 32'(any_pulse), 0);
        check("rst_tick", 32'(tick), 0);
        @(negedge clk) reset = 1'b0;

        // async reset while tick is high clears it at once
        for (int g = 0; g < 20; g++) begin
            @(posedge clk); #1;
            if (tick) break;
        end
        check("tick_seen_before_rst", 32'(tick), 1);
        #1 reset = 1'b1;
        #1 check("rst_async_tick", 32'(tick), 0);
        @(negedge clk) reset = 1'b0;
        n = 0;
        for (int g = 0; g < 20; g++) begin
            @(posedge clk); #1;
            n++;
            if (tick) break;
        end
        check("tick_first_latency", 32'(n), 4);
        n = 0;
        for (int g = 0; g < 20; g++) begin
            @(posedge clk); #1;
            n++;
            if (tick) break;
        end
        check("tick_period", 32'(n), 4);

        // clean press of store key: one pulse, no repeats
        p0 = pcnt[4];
        skip_ticks(1);
        btn_in[4] = 1'b1;
        ticks_until(4, 1'b1, n);
        check("store_press_latency", 32'(n), 3);
        skip_ticks(40);
        check("store_level_held", 32'(key_level[4]), 1);
        check("store_pulse_count", 32'(pcnt[4] - p0), 1);
        skip_ticks(1);
        btn_in[4] = 1'b0;
        ticks_until(4, 1'b0, n);
        check("store_release_latency", 32'(n), 3);
        check("store_no_release_pulse", 32'(pcnt[4] - p0), 1);

        // bounce on digit 0, then settle high
        p0 = pcnt[0];
        skip_ticks(1);
        for (int k = 0; k < 10; k++) begin
            btn_in[0] = (k % 2 == 0);
            skip_ticks(1);
        end
        check("bounce_no_pulse", 32'(pcnt[0] - p0), 0);
        check("bounce_no_level", 32'(key_level[0]), 0);
        btn_in[0] = 1'b1;
        ticks_until(0, 1'b1, n);
        check("bounce_settle_latency", 32'(n), 3);
        repeat (3) @(posedge clk);
        #1 check("bounce_single_pulse", 32'(pcnt[0] - p0), 1);
        btn_in[0] = 1'b0;
        ticks_until(0, 1'b0, n);
        check("bounce_released", 32'(key_level[0]), 0);

        // auto-repeat on digit 1, released so the tick-21 terminal count is cancelled
        watch = 1;
        ev_q.delete();
        skip_ticks(1);
        btn_in[1] = 1'b1;
        ticks_until(1, 1'b1, n);
        check("rpt_press_latency", 32'(n), 3);
        skip_ticks(18);
        btn_in[1] = 1'b0;
        ticks_until(1, 1'b0, n);
        check("rpt_release_latency", 32'(n), 3);
        skip_ticks(8);
        exp_q = '{32'd0, 32'd5, 32'd7, 32'd9, 32'd11, 32'd13, 32'd15, 32'd17, 32'd19};
        check_events("rpt");

        // simultaneous press of digit 2 and check key
        p_any = any_cnt;
        skip_ticks(1);
        btn_in = btn_in | 6'b100100;
        ticks_until(2, 1'b1, n);
        check("sim_level5", 32'(key_level[5]), 1);
        repeat (3) @(posedge clk);
        #1;
        check("sim_pulse_vec", 32'(last_vec), 32'h24);
        check("sim_any_count", 32'(any_cnt - p_any), 1);
        btn_in = btn_in & ~6'b100100;
        ticks_until(2, 1'b0, n);
        ticks_until(5, 1'b0, n);
        check("sim_released", 32'(key_level), 0);

        // reset while digit 3 is repeating; key still held afterwards
        watch = 3;
        skip_ticks(1);
        btn_in[3] = 1'b1;
        ticks_until(3, 1'b1, n);
        skip_ticks(8);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_level", 32'(key_level), 0);
        check("rst_mid_pulse", 32'(key_pulse), 0);
        ev_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ticks_until(3, 1'b1, n);
        check("rst_mid_requalify", 32'(n), 3);
        skip_ticks(8);
        exp_q = '{32'd0, 32'd5, 32'd7};
        check_events("rst_mid_rpt");
        btn_in[3] = 1'b0;
        ticks_until(3, 1'b0, n);
        check("rst_mid_released", 32'(key_level[3]), 0);

        // whole-run pulse shape checks
        check("pulse_width_one", 32'(wide_err), 0);
        check("any_pulse_aligned", 32'(any_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
